// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and
// the helper that classifies an op as iterative.
package alu_pkg;

   // Legacy single-cycle encodings (bit3 = 0)
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   // Extended encodings (bit3 = 1)
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;
   // 1110 and 1111 are reserved and behave as XOR

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ops that run through the iterative shift-add / restoring-divide path
   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle datapath. Iterative op codes never reach the
// result register through this path; they fall into the XOR default.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res
);

   logic [SHW-1:0] sh;

   assign sh = b[SHW-1:0];

   // Select the single-cycle result; shifts use only the low SHW bits of b
   always_comb begin
      res = a ^ b;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = a + b;
         OP_XOR:  res = a ^ b;
         OP_NOR:  res = ~(a | b);
         OP_SRL:  res = a >> sh;
         OP_SUB:  res = a - b;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  res = a << sh;
         OP_SRA:  res = $unsigned($signed(a) >>> sh);
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: res = a ^ b;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides. Single-cycle ops go
// IDLE->DONE; MUL/DIVU/REMU spend WIDTH cycles in BUSY, one bit per cycle.
// The iterative path shares three registers between multiply and divide:
//   x_reg   multiplicand (shifted left)   / divisor (static)
//   y_reg   multiplier   (shifted right)  / dividend shifting out, quotient in
//   acc_reg product accumulator           / partial remainder
// Division by zero needs no special case: the restoring step always
// succeeds, so the quotient fills with ones and the remainder becomes a.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             busy
);

   state_t           state_reg, state_next;
   logic             accept, last;
   logic [SHW:0]     count_reg;
   logic [3:0]       op_reg;
   logic [WIDTH-1:0] x_reg, y_reg, acc_reg;
   logic [WIDTH-1:0] x_next, y_next, acc_next, step_res;
   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] comb_res;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op  (op),
      .a   (a),
      .b   (b),
      .res (comb_res)
   );

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == BUSY);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic plus accept/last-iteration strobes
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = is_multicycle(op) ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (count_reg == (SHW+1)'(1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift-add or restoring-divide step from the current registers
   always_comb begin
      shifted = {acc_reg, y_reg[WIDTH-1]};
      diff    = shifted - {1'b0, x_reg};
      if (op_reg == OP_MUL) begin
         acc_next = acc_reg + (y_reg[0] ? x_reg : '0);
         x_next   = x_reg << 1;
         y_next   = y_reg >> 1;
         step_res = acc_next;
      end else begin
         acc_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         x_next   = x_reg;
         y_next   = {y_reg[WIDTH-2:0], ~diff[WIDTH]};
         step_res = (op_reg == OP_REMU) ? acc_next : y_next;
      end
   end

   // Operand latch, iteration registers and the result/zero register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
         op_reg    <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         acc_reg   <= '0;
         res       <= '0;
         zero      <= 1'b1;
      end else if (accept) begin
         if (is_multicycle(op)) begin
            op_reg    <= op;
            x_reg     <= (op == OP_MUL) ? a : b;
            y_reg     <= (op == OP_MUL) ? b : a;
            acc_reg   <= '0;
            count_reg <= (SHW+1)'(WIDTH);
         end else begin
            res  <= comb_res;
            zero <= (comb_res == '0);
         end
      end else if (state_reg == BUSY) begin
         x_reg     <= x_next;
         y_reg     <= y_next;
         acc_reg   <= acc_next;
         count_reg <= count_reg - (SHW+1)'(1);
         if (last) begin
            res  <= step_res;
            zero <= (step_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes hand-computed results on
// accept, an independent monitor pops and compares on each output handshake.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic         zero;
   logic         busy;

   typedef struct {
      logic [W-1:0] res;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Present an op, wait (bounded) for acceptance, queue its expected result
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ex, input string nm, input bit push);
      int n;
      op = o; a = x; b = y; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         check({"accept ", nm}, 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) sb.push_back('{ex, nm});
      #1 in_valid = 1'b0;
   endtask

   // Bounded wait until every queued result has been seen
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compare on every output handshake (sampled mid-cycle)
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, " res"}, res, e.res);
               check({e.name, " zero"}, 32'(zero), 32'(e.res == '0));
            end
         end
      end
   end

   // Stimulus
   initial begin
      int           nbusy;
      logic [W-1:0] held;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset res", res, 32'h0);
      check("reset zero", 32'(zero), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1 check("in_ready after reset", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Single-cycle ops back-to-back
      issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, "ADD wrap", 1'b1);
      @(negedge clk);
      check("ADD latency out_valid", 32'(out_valid), 32'd1);
      issue(OP_SLT,  32'h80000000, 32'h1,        32'h1,        "SLT", 1'b1);
      issue(OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, "NOR", 1'b1);
      issue(OP_SRL,  32'h80000000, 32'h21,       32'h40000000, "SRL", 1'b1);
      issue(OP_SRA,  32'h80000000, 32'h4,        32'hF8000000, "SRA", 1'b1);
      issue(OP_SLTU, 32'h80000000, 32'h1,        32'h0,        "SLTU", 1'b1);
      issue(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, "AND", 1'b1);
      issue(OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, "OR", 1'b1);
      issue(OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "XOR", 1'b1);
      issue(OP_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, "SUB", 1'b1);
      issue(OP_SLL,  32'h1,        32'h1F,       32'h80000000, "SLL", 1'b1);
      issue(4'b1110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, "RSV", 1'b1);

      // Iterative ops
      issue(OP_DIVU, 32'd100,      32'd7, 32'd14,       "DIVU 100/7", 1'b1);
      issue(OP_REMU, 32'd100,      32'd7, 32'd2,        "REMU 100/7", 1'b1);
      issue(OP_DIVU, 32'd12345,    32'd0, 32'hFFFFFFFF, "DIVU x/0", 1'b1);
      issue(OP_REMU, 32'd5,        32'd0, 32'd5,        "REMU 5/0", 1'b1);
      issue(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, "MUL -1*-1", 1'b1);
      issue(OP_DIVU, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, "DIVU max/1", 1'b1);
      drain();

      // MUL with backpressure
      @(posedge clk); #1 out_ready = 1'b0;
      issue(OP_MUL, 32'h00010001, 32'h00010001, 32'h00020001, "MUL", 1'b1);
      nbusy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (busy && !in_ready) nbusy++;
      end
      check("MUL busy cycles", 32'(nbusy), 32'd32);
      check("MUL out_valid", 32'(out_valid), 32'd1);
      held = 32'h00020001;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
         @(negedge clk);
         check("backpressure res", res, held);
         check("backpressure in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      issue(OP_ADD, 32'd7, 32'd8, 32'd15, "ADD after MUL", 1'b1);
      drain();

      // Reset in the middle of a DIVU
      @(posedge clk); #1;
      issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, "DIVU aborted", 1'b0);
      repeat (14) @(negedge clk);
      check("abort busy before rst", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort res", res, 32'h0);
      check("abort zero", 32'(zero), 32'd1);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("abort in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("no output for aborted op", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      issue(OP_ADD, 32'd2, 32'd3, 32'd5, "ADD after reset", 1'b1);
      drain();

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
